// File: rtl/spi_bus_arbiter_if.sv
// Signal bundle between the two SPI masters, the board SPI pins and spi_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface spi_bus_arbiter_if;
    logic i_M0_REQ;
    logic i_M1_REQ;
    logic i_M0_CS;
    logic i_M1_CS;
    logic i_M0_CLK;
    logic i_M1_CLK;
    logic i_M0_MOSI;
    logic i_M1_MOSI;
    logic o_M0_MISO;
    logic o_M1_MISO;
    logic o_M0_GRANT;
    logic o_M1_GRANT;
    logic o_SPI_CLK;
    logic o_SPI_MOSI;
    logic o_SPI_CS;
    logic i_SPI_MISO;
    logic o_TIMEOUT;

    modport slave (
        input  i_M0_REQ, i_M1_REQ, i_M0_CS, i_M1_CS, i_M0_CLK, i_M1_CLK,
               i_M0_MOSI, i_M1_MOSI, i_SPI_MISO,
        output o_M0_MISO, o_M1_MISO, o_M0_GRANT, o_M1_GRANT,
               o_SPI_CLK, o_SPI_MOSI, o_SPI_CS, o_TIMEOUT
    );

    modport master (
        output i_M0_REQ, i_M1_REQ, i_M0_CS, i_M1_CS, i_M0_CLK, i_M1_CLK,
               i_M0_MOSI, i_M1_MOSI, i_SPI_MISO,
        input  o_M0_MISO, o_M1_MISO, o_M0_GRANT, o_M1_GRANT,
               o_SPI_CLK, o_SPI_MOSI, o_SPI_CS, o_TIMEOUT
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI flash bus for two masters, with a CS-high guard
// gap between owners and a hold timeout that revokes and locks out a hung owner.
module spi_bus_arbiter #(
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic               clk,
    input logic               reset,
    spi_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1,
        ST_GUARD
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    state_t          state;
    logic            last_owner;
    logic [GW-1:0]   guard_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            lockout0;
    logic            lockout1;
    logic            grant0;
    logic            grant1;
    logic            timeout_q;

    logic            elig0;
    logic            elig1;
    logic            pick_valid;
    logic            pick_id;
    logic            owner_req;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        elig0      = bus.i_M0_REQ && !lockout0;
        elig1      = bus.i_M1_REQ && !lockout1;
        pick_valid = elig0 || elig1;
        pick_id    = 1'b0;
        if (elig0 && elig1) begin
            pick_id = ~last_owner;
        end else if (elig1) begin
            pick_id = 1'b1;
        end
        owner_req = (state == ST_OWN1) ? bus.i_M1_REQ : bus.i_M0_REQ;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            guard_cnt  <= '0;
            tmo_cnt    <= '0;
            lockout0   <= 1'b0;
            lockout1   <= 1'b0;
            grant0     <= 1'b0;
            grant1     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (!bus.i_M0_REQ) lockout0 <= 1'b0;
            if (!bus.i_M1_REQ) lockout1 <= 1'b0;

            case (state)
                // The last GUARD cycle arbitrates exactly like IDLE, so turnaround is GUARD_CYCLES.
                ST_IDLE, ST_GUARD: begin
                    if (state == ST_GUARD && guard_cnt != GUARD_LAST) begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end else if (pick_valid) begin
                        state      <= pick_id ? ST_OWN1 : ST_OWN0;
                        grant0     <= !pick_id;
                        grant1     <= pick_id;
                        last_owner <= pick_id;
                        tmo_cnt    <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_OWN0, ST_OWN1: begin
                    if (!owner_req) begin
                        state     <= ST_GUARD;
                        grant0    <= 1'b0;
                        grant1    <= 1'b0;
                        guard_cnt <= '0;
                    end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
                        state     <= ST_GUARD;
                        grant0    <= 1'b0;
                        grant1    <= 1'b0;
                        guard_cnt <= '0;
                        timeout_q <= 1'b1;
                        if (state == ST_OWN1) lockout1 <= 1'b1;
                        else                  lockout0 <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Zero-latency pin mux keyed on registered state keeps Mode 0 MISO sampling aligned.
    always_comb begin
        bus.o_SPI_CS   = 1'b1;
        bus.o_SPI_CLK  = 1'b0;
        bus.o_SPI_MOSI = 1'b0;
        bus.o_M0_MISO  = 1'b0;
        bus.o_M1_MISO  = 1'b0;
        case (state)
            ST_OWN0: begin
                bus.o_SPI_CS   = bus.i_M0_CS;
                bus.o_SPI_CLK  = bus.i_M0_CLK;
                bus.o_SPI_MOSI = bus.i_M0_MOSI;
                bus.o_M0_MISO  = bus.i_SPI_MISO;
            end
            ST_OWN1: begin
                bus.o_SPI_CS   = bus.i_M1_CS;
                bus.o_SPI_CLK  = bus.i_M1_CLK;
                bus.o_SPI_MOSI = bus.i_M1_MOSI;
                bus.o_M1_MISO  = bus.i_SPI_MISO;
            end
            default: ;
        endcase
    end

    assign bus.o_M0_GRANT = grant0;
    assign bus.o_M1_GRANT = grant1;
    assign bus.o_TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: dut_a (guard 2, timeout 16) covers arbitration and timeout,
// dut_b (guard 1, timeout disabled) covers pin muxing and the long-hold case.
module tb_spi_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_bus_arbiter_if ia();
    spi_bus_arbiter_if ib();

    spi_bus_arbiter #(.GUARD_CYCLES(2), .TIMEOUT_CYCLES(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    spi_bus_arbiter #(.GUARD_CYCLES(1), .TIMEOUT_CYCLES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    int total  = 0;
    int passed = 0;
    int tmo_a  = 0;
    int tmo_b  = 0;

    always @(posedge clk) begin
        if (ia.o_TIMEOUT === 1'b1) tmo_a++;
        if (ib.o_TIMEOUT === 1'b1) tmo_b++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ia.i_M0_REQ = 0; ia.i_M1_REQ = 0; ia.i_M0_CS = 1; ia.i_M1_CS = 1;
        ia.i_M0_CLK = 0; ia.i_M1_CLK = 0; ia.i_M0_MOSI = 0; ia.i_M1_MOSI = 0;
        ia.i_SPI_MISO = 0;
        ib.i_M0_REQ = 0; ib.i_M1_REQ = 0; ib.i_M0_CS = 1; ib.i_M1_CS = 1;
        ib.i_M0_CLK = 0; ib.i_M1_CLK = 0; ib.i_M0_MOSI = 0; ib.i_M1_MOSI = 0;
        ib.i_SPI_MISO = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        logic [5:0] pins;
        do_reset();
        pins = {ia.o_SPI_CS, ia.o_SPI_CLK, ia.o_SPI_MOSI, ia.o_M0_GRANT, ia.o_M1_GRANT, ia.o_TIMEOUT};
        total++;
        if (pins !== 6'b100000) $display("FAIL reset_a: cs,clk,mosi,g0,g1,tmo got %b want 100000", pins);
        else passed++;
        pins = {ib.o_SPI_CS, ib.o_SPI_CLK, ib.o_SPI_MOSI, ib.o_M0_GRANT, ib.o_M1_GRANT, ib.o_TIMEOUT};
        total++;
        if (pins !== 6'b100000) $display("FAIL reset_b: cs,clk,mosi,g0,g1,tmo got %b want 100000", pins);
        else passed++;

        ia.i_SPI_MISO = 1;
        #1;
        total++;
        if ({ia.o_M0_MISO, ia.o_M1_MISO} !== 2'b00)
            $display("FAIL reset_miso: got %b want 00", {ia.o_M0_MISO, ia.o_M1_MISO});
        else passed++;

        ia.i_M0_REQ = 1;
        ia.i_M0_CS  = 0;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_SPI_CS} !== 2'b10)
            $display("FAIL reset_pre_own0: g0,cs got %b want 10", {ia.o_M0_GRANT, ia.o_SPI_CS});
        else passed++;

        reset = 1;
        tick();
        pins = {ia.o_SPI_CS, ia.o_SPI_CLK, ia.o_SPI_MOSI, ia.o_M0_GRANT, ia.o_M1_GRANT, ia.o_TIMEOUT};
        total++;
        if (pins !== 6'b100000) $display("FAIL reset_mid_own0: got %b want 100000", pins);
        else passed++;
        idle_inputs();
        reset = 0;
        tick();
    endtask

    task automatic test_single_grant();
        logic [31:0] cmd;
        logic [31:0] shifted;
        logic [7:0]  miso_byte;
        logic [7:0]  rx;
        int          pin_err;
        logic        m1_seen;
        cmd       = 32'h03012345;
        miso_byte = 8'hA5;
        shifted   = '0;
        rx        = '0;
        pin_err   = 0;
        m1_seen   = 0;

        ib.i_M0_REQ = 1;
        #1;
        total++;
        if (ib.o_M0_GRANT !== 1'b0) $display("FAIL single_early_grant: got %b want 0", ib.o_M0_GRANT);
        else passed++;
        tick();
        total++;
        if ({ib.o_M0_GRANT, ib.o_M1_GRANT} !== 2'b10)
            $display("FAIL single_grant: g0,g1 got %b want 10", {ib.o_M0_GRANT, ib.o_M1_GRANT});
        else passed++;

        tick();
        ib.i_M0_CS = 0;
        for (int i = 31; i >= 0; i--) begin
            ib.i_M0_MOSI = cmd[i];
            ib.i_M0_CLK  = 0;
            #1;
            if (ib.o_SPI_CLK !== 1'b0 || ib.o_SPI_CS !== 1'b0) pin_err++;
            tick();
            ib.i_M0_CLK = 1;
            #1;
            if (ib.o_SPI_CLK !== 1'b1 || ib.o_SPI_CS !== 1'b0) pin_err++;
            shifted = {shifted[30:0], ib.o_SPI_MOSI};
            tick();
        end
        for (int i = 7; i >= 0; i--) begin
            ib.i_M0_CLK   = 0;
            ib.i_SPI_MISO = miso_byte[i];
            tick();
            ib.i_M0_CLK = 1;
            #1;
            rx      = {rx[6:0], ib.o_M0_MISO};
            m1_seen = m1_seen | ib.o_M1_MISO;
            tick();
        end
        total++;
        if (shifted !== 32'h03012345) $display("FAIL single_mosi: got %h want 03012345", shifted);
        else passed++;
        total++;
        if (pin_err !== 0) $display("FAIL single_clk_cs: mismatching half-bits got %0d want 0", pin_err);
        else passed++;
        total++;
        if (rx !== 8'hA5) $display("FAIL single_miso0: got %h want a5", rx);
        else passed++;
        total++;
        if (m1_seen !== 1'b0) $display("FAIL single_miso1_leak: got %b want 0", m1_seen);
        else passed++;

        ib.i_M0_CLK = 0;
        ib.i_M0_CS  = 1;
        tick();
        ib.i_M0_REQ = 0;
        tick();
        total++;
        if ({ib.o_M0_GRANT, ib.o_SPI_CS} !== 2'b01)
            $display("FAIL single_release: g0,cs got %b want 01", {ib.o_M0_GRANT, ib.o_SPI_CS});
        else passed++;
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] obs;
        do_reset();
        ia.i_M0_REQ = 1;
        ia.i_M1_REQ = 1;
        ia.i_M1_CS  = 0;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_M1_GRANT} !== 2'b10)
            $display("FAIL rr_first_m0: g0,g1 got %b want 10", {ia.o_M0_GRANT, ia.o_M1_GRANT});
        else passed++;
        repeat (3) tick();

        ia.i_M0_REQ = 0;
        tick();
        obs = {ia.o_M0_GRANT, ia.o_M1_GRANT, ia.o_SPI_CS};
        tick();
        obs = obs | {ia.o_M0_GRANT, ia.o_M1_GRANT, ~ia.o_SPI_CS};
        total++;
        if (obs !== 3'b001) $display("FAIL rr_guard_gap: g0,g1,cs(or) got %b want 001", obs);
        else passed++;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_M1_GRANT, ia.o_SPI_CS} !== 3'b010)
            $display("FAIL rr_second_m1: g0,g1,cs got %b want 010",
                     {ia.o_M0_GRANT, ia.o_M1_GRANT, ia.o_SPI_CS});
        else passed++;

        ia.i_M0_REQ = 1;
        repeat (2) tick();
        ia.i_M1_REQ = 0;
        tick();
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_M1_GRANT} !== 2'b00)
            $display("FAIL rr_gap_m1_m0: g0,g1 got %b want 00", {ia.o_M0_GRANT, ia.o_M1_GRANT});
        else passed++;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_M1_GRANT} !== 2'b10)
            $display("FAIL rr_third_m0: g0,g1 got %b want 10", {ia.o_M0_GRANT, ia.o_M1_GRANT});
        else passed++;

        // M0 re-requests during the guard gap, creating a tie that M1 must win.
        ia.i_M1_REQ = 1;
        repeat (2) tick();
        ia.i_M0_REQ = 0;
        tick();
        ia.i_M0_REQ = 1;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_M1_GRANT} !== 2'b00)
            $display("FAIL rr_tie_gap: g0,g1 got %b want 00", {ia.o_M0_GRANT, ia.o_M1_GRANT});
        else passed++;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_M1_GRANT} !== 2'b01)
            $display("FAIL rr_fourth_tie_m1: g0,g1 got %b want 01", {ia.o_M0_GRANT, ia.o_M1_GRANT});
        else passed++;
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int start_tmo;
        int hold_err;
        int regrant;
        do_reset();
        start_tmo = tmo_a;
        hold_err  = 0;
        regrant   = 0;
        ia.i_M1_REQ = 1;
        tick();
        total++;
        if (ia.o_M1_GRANT !== 1'b1) $display("FAIL tmo_grant_m1: got %b want 1", ia.o_M1_GRANT);
        else passed++;
        ia.i_M0_REQ = 1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (ia.o_M1_GRANT !== 1'b1 || ia.o_TIMEOUT !== 1'b0) hold_err++;
        end
        total++;
        if (hold_err !== 0) $display("FAIL tmo_hold_16: bad cycles got %0d want 0", hold_err);
        else passed++;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_M1_GRANT, ia.o_TIMEOUT} !== 3'b001)
            $display("FAIL tmo_revoke: g0,g1,tmo got %b want 001",
                     {ia.o_M0_GRANT, ia.o_M1_GRANT, ia.o_TIMEOUT});
        else passed++;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_M1_GRANT, ia.o_TIMEOUT} !== 3'b000)
            $display("FAIL tmo_guard2: g0,g1,tmo got %b want 000",
                     {ia.o_M0_GRANT, ia.o_M1_GRANT, ia.o_TIMEOUT});
        else passed++;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_M1_GRANT} !== 2'b10)
            $display("FAIL tmo_m0_after_guard: g0,g1 got %b want 10", {ia.o_M0_GRANT, ia.o_M1_GRANT});
        else passed++;
        total++;
        if (tmo_a - start_tmo !== 1) $display("FAIL tmo_pulse_count: got %0d want 1", tmo_a - start_tmo);
        else passed++;

        repeat (4) tick();
        ia.i_M0_REQ = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ia.o_M1_GRANT === 1'b1) regrant++;
        end
        total++;
        if (regrant !== 0) $display("FAIL tmo_lockout: m1 grant cycles got %0d want 0", regrant);
        else passed++;

        ia.i_M1_REQ = 0;
        tick();
        ia.i_M1_REQ = 1;
        tick();
        total++;
        if (ia.o_M1_GRANT !== 1'b1) $display("FAIL tmo_lockout_clear: g1 got %b want 1", ia.o_M1_GRANT);
        else passed++;
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_release_vs_expiry();
        int start_tmo;
        int hold_err;
        do_reset();
        start_tmo = tmo_a;
        hold_err  = 0;
        ia.i_M0_REQ = 1;
        tick();
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (ia.o_M0_GRANT !== 1'b1) hold_err++;
        end
        total++;
        if (hold_err !== 0) $display("FAIL rel_hold: bad cycles got %0d want 0", hold_err);
        else passed++;
        ia.i_M0_REQ = 0;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_TIMEOUT} !== 2'b00)
            $display("FAIL rel_on_expiry: g0,tmo got %b want 00", {ia.o_M0_GRANT, ia.o_TIMEOUT});
        else passed++;
        ia.i_M0_REQ = 1;
        tick();
        total++;
        if ({ia.o_M0_GRANT, ia.o_TIMEOUT} !== 2'b00)
            $display("FAIL rel_guard: g0,tmo got %b want 00", {ia.o_M0_GRANT, ia.o_TIMEOUT});
        else passed++;
        tick();
        total++;
        if (ia.o_M0_GRANT !== 1'b1) $display("FAIL rel_regrant: g0 got %b want 1", ia.o_M0_GRANT);
        else passed++;
        ia.i_M0_REQ = 0;
        repeat (3) tick();
        total++;
        if (tmo_a !== start_tmo) $display("FAIL rel_no_pulse: pulses got %0d want 0", tmo_a - start_tmo);
        else passed++;
        idle_inputs();
        repeat (2) tick();
    endtask

    task automatic test_timeout_disabled();
        int start_tmo;
        int drop_cnt;
        do_reset();
        start_tmo = tmo_b;
        drop_cnt  = 0;
        ib.i_M0_REQ = 1;
        tick();
        ib.i_M1_REQ = 1;
        ib.i_M1_CS  = 0;
        for (int k = 0; k < 10000; k++) begin
            tick();
            if (ib.o_M0_GRANT !== 1'b1) drop_cnt++;
        end
        total++;
        if (drop_cnt !== 0 || tmo_b !== start_tmo)
            $display("FAIL notmo_hold: dropped cycles %0d pulses %0d want 0 0", drop_cnt, tmo_b - start_tmo);
        else passed++;
        ib.i_M0_REQ = 0;
        tick();
        total++;
        if ({ib.o_M0_GRANT, ib.o_M1_GRANT, ib.o_SPI_CS} !== 3'b001)
            $display("FAIL notmo_gap: g0,g1,cs got %b want 001",
                     {ib.o_M0_GRANT, ib.o_M1_GRANT, ib.o_SPI_CS});
        else passed++;
        tick();
        total++;
        if ({ib.o_M0_GRANT, ib.o_M1_GRANT, ib.o_SPI_CS} !== 3'b010)
            $display("FAIL notmo_handover: g0,g1,cs got %b want 010",
                     {ib.o_M0_GRANT, ib.o_M1_GRANT, ib.o_SPI_CS});
        else passed++;
        idle_inputs();
        repeat (3) tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_timeout();
        test_release_vs_expiry();
        test_timeout_disabled();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the single external SPI flash bus (o_SPI_CLK/o_SPI_MOSI/o_SPI_CS/i_SPI_MISO) between two SPI masters: master 0 is the 6809 flash read path, master 1 is a secondary engine such as a boot copier or flash programmer. It sits between those masters and the board pins. It grants the bus with a request/grant handshake and round-robin fairness, and enforces a chip-select-high guard gap between owners. A hung owner is revoked by a hold timeout.

## Interface
- GUARD_CYCLES, 2: cycles the bus idles (CS high) between owners; legal range ≥1.
- TIMEOUT_CYCLES, 4096: maximum cycles one grant may be held; 0 disables the timeout.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_M0_REQ / i_M1_REQ  in  1  bus request; held high for the whole transaction.
- i_M0_CS / i_M1_CS  in  1  master's chip select, active low.
- i_M0_CLK / i_M1_CLK  in  1  master's SPI clock.
- i_M0_MOSI / i_M1_MOSI  in  1  master's MOSI.
- o_M0_MISO / o_M1_MISO  out  1  MISO returned to master; 0 when not owner.
- o_M0_GRANT / o_M1_GRANT  out  1  registered grant; the master drives its pins only while this is high.
- o_SPI_CLK  out  1  bus SPI clock (Mode 0).
- o_SPI_MOSI  out  1  bus MOSI.
- o_SPI_CS  out  1  bus chip select, active low.
- i_SPI_MISO  in  1  bus MISO.
- o_TIMEOUT  out  1  one-cycle pulse when a grant is revoked by the timeout.

## Operation
- States: IDLE, OWN0, OWN1, GUARD.
- Registers: state, last_owner (1 bit), guard counter, timeout counter (width $clog2(TIMEOUT_CYCLES+1)), lockout0/lockout1.
- Reset (any state, mid-transfer included) sets:
  - state=IDLE, grants=0, o_TIMEOUT=0;
  - last_owner=1, so master 0 wins the first tie;
  - counters=0, lockouts=0.
- Bus pins are a combinational mux on registered state:
  - OWNx: o_SPI_CS/CLK/MOSI = i_Mx_CS/CLK/MOSI, and o_Mx_MISO = i_SPI_MISO.
  - Otherwise: CS=1, CLK=0, MOSI=0, both MISO outputs=0.
- A request is eligible when i_Mx_REQ=1 and lockoutx=0.
- IDLE:
  - One eligible request: go to that OWNx.
  - Both eligible: grant the master ≠ last_owner.
  - Entering OWNx sets o_Mx_GRANT=1 and last_owner=x, and clears the timeout counter.
- OWNx:
  - i_Mx_REQ=0: go to GUARD and drop the grant.
  - Else, if TIMEOUT_CYCLES≠0 and the counter = TIMEOUT_CYCLES-1: go to GUARD, drop the grant, pulse o_TIMEOUT, set lockoutx.
  - Otherwise increment the timeout counter.
  - REQ drop and timeout expiry in the same cycle count as a normal release: no pulse, no lockout.
- GUARD:
  - Count GUARD_CYCLES cycles.
  - On the final GUARD cycle, apply the IDLE arbitration directly (straight to OWNx if anything is eligible), else go to IDLE.
- Lockoutx clears on any cycle in which i_Mx_REQ=0. A revoked master must drop REQ before it can be re-granted.
- The grant of a non-owner is always 0; both grants are never high together.

## Timing
- Grant latency: REQ high sampled at edge N in IDLE → GRANT high after edge N. The pins follow the master from that cycle on.
- Release: REQ low sampled at edge M → GRANT low and CS high after edge M.
- Minimum turnaround: a pending request is granted at edge M+GUARD_CYCLES, so CS stays high for exactly GUARD_CYCLES cycles.
- The pin mux adds zero latency. MISO reaches the owner in the same cycle, preserving Mode 0 sample alignment.
- Timeout: a grant is held for exactly TIMEOUT_CYCLES cycles. o_TIMEOUT is high in the first GUARD cycle only.
- The master must itself hold CS high and CLK low for its first and last granted cycles; the arbiter does not reshape the master's signals.

## Test plan
- **Reset values:** after reset, with no requests → o_SPI_CS=1, CLK=0, MOSI=0, both grants 0, o_TIMEOUT=0; assert reset mid-OWN0 → the same values one edge later.
- **Single grant:** i_M0_REQ=1 at edge 10 → o_M0_GRANT=1 after edge 10; master 0 drives a 0x03 read command plus address on its pins → the bus pins match bit-for-bit; MISO byte 0xA5 is returned on o_M0_MISO only.
- **Simultaneous requests:** both REQs at once after reset → M0 granted first; M0 releases → M1 granted exactly GUARD_CYCLES(2) cycles later with CS high throughout; repeat → alternation M0,M1,M0,M1.
- **Timeout:** with TIMEOUT_CYCLES=16, M1 holds REQ → the grant drops after 16 cycles, o_TIMEOUT pulses once, M0's pending request is granted 2 cycles later; M1 keeps REQ high → never re-granted until it drops REQ for ≥1 cycle.
- **Release vs. expiry:** REQ drop on the expiry cycle → no o_TIMEOUT pulse, normal GUARD entry.
- **Timeout disabled:** GUARD_CYCLES=1, TIMEOUT_CYCLES=0 → a 10000-cycle hold is never revoked; handover gap is exactly 1 cycle.
